// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_sequencer
// Purpose  : Issue stage for the 4-bit combinational ALU. Buffers requests
//            in a FIFO, drives registered operands into the ALU one at a
//            time, captures each result and hands it downstream in order.
// Options  : ALU_OP_SEQUENCER_TAG_EN adds a 4-bit res_tag output that
//            numbers results modulo 16 from reset.
// Revision : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 4,
   parameter int CODE_W = 2,
   parameter int RES_W  = DATA_W + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CODE_W-1:0] in_code,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   output logic [CODE_W-1:0] alu_code,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic [RES_W-1:0]  alu_c,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [RES_W-1:0]  res_data,
`ifdef ALU_OP_SEQUENCER_TAG_EN
   output logic [3:0]        res_tag,
`endif
   output logic              busy
);

   localparam int C_PTR_W   = $clog2(DEPTH);
   localparam int C_CNT_W   = C_PTR_W + 1;
   localparam int C_ENTRY_W = CODE_W + 2 * DATA_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      HOLD = 2'd2
   } state_t;

   // FIFO storage and bookkeeping
   logic [C_ENTRY_W-1:0] mem_q [DEPTH];
   logic [C_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [C_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [C_CNT_W-1:0]   count_q,  count_d;

   // Issue/result pipeline state
   state_t              state_q;
   logic [CODE_W-1:0]   alu_code_q;
   logic [DATA_W-1:0]   alu_a_q;
   logic [DATA_W-1:0]   alu_b_q;
   logic [RES_W-1:0]    res_data_q;
   logic                res_valid_q;

`ifdef ALU_OP_SEQUENCER_TAG_EN
   logic [3:0]          tag_cnt_q;
   logic [3:0]          res_tag_q;
`endif

   logic                 w_push;
   logic                 w_pop;
   logic                 w_fifo_ne;
   logic [C_ENTRY_W-1:0] w_head;
   logic [CODE_W-1:0]    w_head_code;
   logic [DATA_W-1:0]    w_head_a;
   logic [DATA_W-1:0]    w_head_b;

   // in_ready looks only at the registered count, so a pop in a full cycle
   // never lets a new request slip in during that same cycle.
   assign in_ready  = (count_q != C_CNT_W'(DEPTH));
   assign w_fifo_ne = (count_q != '0);
   assign w_push    = in_valid & in_ready;
   // The FSM takes the head entry from IDLE, or from HOLD when the current
   // result is being acknowledged.
   assign w_pop     = w_fifo_ne & ((state_q == IDLE) | ((state_q == HOLD) & res_ready));

   assign w_head      = mem_q[rd_ptr_q];
   assign w_head_code = w_head[C_ENTRY_W-1 -: CODE_W];
   assign w_head_a    = w_head[2*DATA_W-1 -: DATA_W];
   assign w_head_b    = w_head[DATA_W-1:0];

   // Next-state for FIFO pointers and occupancy; pointers wrap naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (w_push) begin
         wr_ptr_d = wr_ptr_q + C_PTR_W'(1);
      end
      if (w_pop) begin
         rd_ptr_d = rd_ptr_q + C_PTR_W'(1);
      end
      unique case ({w_push, w_pop})
         2'b10:   count_d = count_q + C_CNT_W'(1);
         2'b01:   count_d = count_q - C_CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO payload storage; contents need no reset since pointers guard them.
   always_ff @(posedge clk) begin
      if (w_push) begin
         mem_q[wr_ptr_q] <= {in_code, in_a, in_b};
      end
   end

   // FIFO pointer and occupancy registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Issue FSM: load operands, wait one cycle for the ALU, capture, hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         alu_code_q  <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         res_data_q  <= '0;
         res_valid_q <= 1'b0;
`ifdef ALU_OP_SEQUENCER_TAG_EN
         tag_cnt_q   <= 4'd0;
         res_tag_q   <= 4'd0;
`endif
      end else begin
         unique case (state_q)
            IDLE: begin
               if (w_fifo_ne) begin
                  alu_code_q <= w_head_code;
                  alu_a_q    <= w_head_a;
                  alu_b_q    <= w_head_b;
                  state_q    <= EXEC;
               end
            end
            EXEC: begin
               res_data_q  <= alu_c;
               res_valid_q <= 1'b1;
`ifdef ALU_OP_SEQUENCER_TAG_EN
               res_tag_q   <= tag_cnt_q;
               tag_cnt_q   <= tag_cnt_q + 4'd1;
`endif
               state_q     <= HOLD;
            end
            HOLD: begin
               if (res_ready) begin
                  res_valid_q <= 1'b0;
                  if (w_fifo_ne) begin
                     alu_code_q <= w_head_code;
                     alu_a_q    <= w_head_a;
                     alu_b_q    <= w_head_b;
                     state_q    <= EXEC;
                  end else begin
                     state_q    <= IDLE;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign alu_code  = alu_code_q;
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign res_data  = res_data_q;
   assign res_valid = res_valid_q;
   assign busy      = w_fifo_ne | (state_q != IDLE);
`ifdef ALU_OP_SEQUENCER_TAG_EN
   assign res_tag   = res_tag_q;
`endif

endmodule
`default_nettype wire
